// File: rtl/wb_request_queue.sv
// Writeback request queue: buffers multi-cycle unit results until the writeback arbiter acks them.
// Optional starvation monitor is built when WB_QUEUE_STARVE_MON_EN is defined.
package pipeline_pkg;
   typedef struct packed {
      logic        valid;
      logic        wren;
      logic [4:0]  rd;
      logic [31:0] data;
   } pipe_t;
endpackage

module wb_request_queue
   import pipeline_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 16
) (
   input  logic  i_clk,
   input  logic  i_rst_n,
   input  logic  i_flush,
   input  pipe_t i_unit_pkg,
   output logic  o_ready,
   input  logic  i_ack_wb,
   output pipe_t o_wb_pkg,
   output logic  o_busy,
   output logic  o_starve
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   pipe_t          mem_q [DEPTH];
   logic [PW-1:0]  rptr_q, rptr_d;
   logic [PW-1:0]  wptr_q, wptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           push;
   logic           pop;

   // Readiness depends only on registered count, so a same-cycle ack never frees a slot.
   assign o_ready = (count_q < CW'(DEPTH));
   assign push    = i_unit_pkg.valid & i_unit_pkg.wren & o_ready & ~i_flush;
   assign pop     = i_ack_wb & (count_q != '0) & ~i_flush;

   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (i_flush) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PW'(1);
         if (pop)  rptr_d = rptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   // Payload storage is masked by count, so it carries no reset.
   always_ff @(posedge i_clk) begin
      if (push) mem_q[wptr_q] <= i_unit_pkg;
   end

   assign o_busy   = (count_q != '0);
   assign o_wb_pkg = (count_q != '0) ? mem_q[rptr_q] : '0;

`ifdef WB_QUEUE_STARVE_MON_EN
   logic [7:0] starve_q, starve_d;

   always_comb begin
      starve_d = starve_q;
      if (i_flush | pop | (count_q == '0)) begin
         starve_d = '0;
      end else if (starve_q != 8'(STARVE_LIMIT)) begin
         starve_d = starve_q + 8'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) starve_q <= '0;
      else          starve_q <= starve_d;
   end

   assign o_starve = (starve_q == 8'(STARVE_LIMIT));
`else
   assign o_starve = 1'b0;
`endif

endmodule

// File: tb/tb_wb_request_queue.sv
// Bench for wb_request_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_request_queue;
   import pipeline_pkg::*;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic  clk = 1'b0;
   logic  rst_n;
   logic  flush_i;
   pipe_t pkg_i;
   logic  ack_i;
   logic  ready_o, busy_o, starve_o;
   pipe_t wb_o;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   pipe_t mq[$];
   int    wait_cnt = 0;

   wb_request_queue #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_flush    (flush_i),
      .i_unit_pkg (pkg_i),
      .o_ready    (ready_o),
      .i_ack_wb   (ack_i),
      .o_wb_pkg   (wb_o),
      .o_busy     (busy_o),
      .o_starve   (starve_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit starve_exp();
`ifdef WB_QUEUE_STARVE_MON_EN
      return (wait_cnt == LIMIT);
`else
      return 1'b0;
`endif
   endfunction

   // Reference: a queue of accepted packages plus a count of cycles the head has waited.
   task automatic model_update();
      bit rdy  = (mq.size() < DEPTH);
      bit push = pkg_i.valid && pkg_i.wren && rdy && !flush_i;
      bit pop  = ack_i && (mq.size() > 0) && !flush_i;
      if (flush_i || pop || mq.size() == 0) wait_cnt = 0;
      else if (wait_cnt < LIMIT)            wait_cnt = wait_cnt + 1;
      if (flush_i) mq.delete();
      else begin
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back(pkg_i);
      end
   endtask

   task automatic tick(input pipe_t p, input logic ack, input logic fl);
      pkg_i   = p;
      ack_i   = ack;
      flush_i = fl;
      @(posedge clk);
      model_update();
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready",  64'(ready_o),  64'(mq.size() < DEPTH));
         chk("busy",   64'(busy_o),   64'(mq.size() > 0));
         chk("wb_pkg", 64'(wb_o),     64'((mq.size() > 0) ? mq[0] : pipe_t'('0)));
         chk("starve", 64'(starve_o), 64'(starve_exp()));
      end
   end

   function automatic pipe_t mk(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] d);
      pipe_t p;
      p.valid = v; p.wren = w; p.rd = rd; p.data = d;
      return p;
   endfunction

   initial begin
      pipe_t idle, A, B, C, nw;
      pipe_t X[3];
      logic  st_lim;
      idle = '0;
      A  = mk(1'b1, 1'b1, 5'd1, 32'hAAAA_0001);
      B  = mk(1'b1, 1'b1, 5'd2, 32'hBBBB_0002);
      C  = mk(1'b1, 1'b1, 5'd3, 32'hCCCC_0003);
      nw = mk(1'b1, 1'b0, 5'd4, 32'hDEAD_BEEF);
      X[0] = mk(1'b1, 1'b1, 5'd10, 32'h1000_0000);
      X[1] = mk(1'b1, 1'b1, 5'd11, 32'h1100_0000);
      X[2] = mk(1'b1, 1'b1, 5'd12, 32'h1200_0000);
`ifdef WB_QUEUE_STARVE_MON_EN
      st_lim = 1'b1;
`else
      st_lim = 1'b0;
`endif

      rst_n = 1'b0; pkg_i = '0; ack_i = 1'b0; flush_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready",  64'(ready_o),  64'd1);
      chk("rst_busy",   64'(busy_o),   64'd0);
      chk("rst_starve", 64'(starve_o), 64'd0);
      chk("rst_wb",     64'(wb_o),     64'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Single push held without ack; starve flags after LIMIT waiting cycles.
      tick(A, 1'b0, 1'b0);
      chk("s1_wb", 64'(wb_o), 64'(A));
      chk("s1_busy", 64'(busy_o), 64'd1);
      chk("s1_ready", 64'(ready_o), 64'd1);
      for (int i = 0; i < 4; i++) begin
         tick(idle, 1'b0, 1'b0);
         chk("s1_hold", 64'(wb_o), 64'(A));
         chk("s1_starve", 64'(starve_o), (i == 3) ? 64'(st_lim) : 64'd0);
      end
      tick(idle, 1'b1, 1'b0);
      chk("s1_starve_clr", 64'(starve_o), 64'd0);
      chk("s1_empty", 64'(busy_o), 64'd0);

      // Fill to full, refuse C even with a same-cycle ack.
      tick(A, 1'b0, 1'b0);
      tick(B, 1'b0, 1'b0);
      chk("s2_full_ready", 64'(ready_o), 64'd0);
      tick(C, 1'b0, 1'b0);
      chk("s2_head_A", 64'(wb_o), 64'(A));
      tick(C, 1'b1, 1'b0);
      chk("s2_head_B", 64'(wb_o), 64'(B));
      chk("s2_ready", 64'(ready_o), 64'd1);
      tick(idle, 1'b1, 1'b0);
      chk("s2_no_C", 64'(busy_o), 64'd0);

      // Simultaneous push and pop at count 1, across pointer wraps.
      tick(A, 1'b0, 1'b0);
      tick(C, 1'b1, 1'b0);
      chk("s3_head_C", 64'(wb_o), 64'(C));
      chk("s3_ready", 64'(ready_o), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick(X[i], 1'b1, 1'b0);
         chk("s3_wrap", 64'(wb_o), 64'(X[i]));
         chk("s3_cnt1", 64'(ready_o), 64'd1);
      end
      tick(idle, 1'b1, 1'b0);

      // Non-writing packages consumed; ack on empty ignored.
      tick(nw, 1'b0, 1'b0);
      chk("s4_busy", 64'(busy_o), 64'd0);
      chk("s4_wb", 64'(wb_o), 64'd0);
      tick(idle, 1'b1, 1'b0);
      chk("s4_ack_empty", 64'(busy_o), 64'd0);
      tick(B, 1'b0, 1'b0);
      chk("s4_push_after", 64'(wb_o), 64'(B));
      tick(idle, 1'b1, 1'b0);

      // Flush beats push and pop; asynchronous reset mid-cycle.
      tick(A, 1'b0, 1'b0);
      tick(B, 1'b0, 1'b0);
      tick(C, 1'b1, 1'b1);
      chk("s5_flush_busy", 64'(busy_o), 64'd0);
      chk("s5_flush_ready", 64'(ready_o), 64'd1);
      chk("s5_flush_wb", 64'(wb_o), 64'd0);
      tick(A, 1'b0, 1'b0);
      tick(B, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      mq.delete();
      wait_cnt = 0;
      #1;
      chk("s5_arst_busy", 64'(busy_o), 64'd0);
      chk("s5_arst_ready", 64'(ready_o), 64'd1);
      chk("s5_arst_wb", 64'(wb_o), 64'd0);
      chk("s5_arst_starve", 64'(starve_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pkg_i = '0;

      // Randomized traffic; the later half acks rarely to exercise starvation.
      for (int i = 0; i < 1600; i++) begin
         pipe_t p;
         int    ackpct;
         ackpct  = (i < 800) ? 50 : 12;
         p.valid = ($urandom_range(0, 9) < 7);
         p.wren  = ($urandom_range(0, 9) < 7);
         p.rd    = 5'($urandom);
         p.data  = $urandom;
         tick(p, ($urandom_range(0, 99) < ackpct), ($urandom_range(0, 99) < 3));
      end
      tick(idle, 1'b1, 1'b0);
      tick(idle, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_request_queue.md
WB_REQUEST_QUEUE -- requirements
Module: wb_request_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2: number of pending writeback entries; power of two, at least 2.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 16: number of unacked head cycles before o_starve asserts; range 1..255.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_flush, input, 1 bit: discard all pending entries (pipeline redirect).
REQ-006 The block SHALL have port i_unit_pkg, input, pipe_t (pipeline_pkg): result package from the multi-cycle unit (LSU/MUL/DIV).
REQ-007 The block SHALL have port o_ready, output, 1 bit: the queue can accept i_unit_pkg this cycle.
REQ-008 The block SHALL have port i_ack_wb, input, 1 bit: the writeback arbiter grants this unit's request this cycle.
REQ-009 The block SHALL have port o_wb_pkg, output, pipe_t: head entry presented to the writeback arbiter.
REQ-010 The block SHALL have port o_busy, output, 1 bit: at least one entry is pending.
REQ-011 The block SHALL have port o_starve, output, 1 bit: the head has waited STARVE_LIMIT cycles without ack.

Function
REQ-012 Storage SHALL be a circular FIFO of DEPTH pipe_t entries, with read pointer, write pointer and a count of width $clog2(DEPTH)+1.
REQ-013 o_ready SHALL equal (count < DEPTH), decoded from registered state only, with no combinational path from i_ack_wb.
REQ-014 Push SHALL occur when i_unit_pkg.valid & i_unit_pkg.wren & o_ready & !i_flush.
REQ-015 Packages with valid=1 and wren=0 SHALL NOT be enqueued; they SHALL be silently consumed.
REQ-016 A push SHALL write the entry at the write pointer and increment the pointer, wrapping from DEPTH-1 to 0.
REQ-017 A pushed entry SHALL appear on o_wb_pkg no earlier than the cycle after the push (1-cycle latency), and SHALL NOT bypass combinationally.
REQ-018 o_wb_pkg SHALL equal the entry at the read pointer when count>0, and all-zeros when count==0.
REQ-019 While un-acked, o_wb_pkg SHALL remain stable, with valid and wren held at 1.
REQ-020 Pop SHALL occur when i_ack_wb & (count>0) & !i_flush, incrementing the read pointer with wrap.
REQ-021 An i_ack_wb with count==0 SHALL be ignored, with no pointer or count change.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-023 When full, a push attempt SHALL be refused (o_ready=0), even if i_ack_wb pops in the same cycle.
REQ-024 i_flush SHALL zero count and both pointers at the next edge, overriding a same-cycle push and pop.
REQ-025 o_busy SHALL equal (count>0).

Reset
REQ-026 While i_rst_n=0, count, pointers and the starve counter SHALL be 0, giving o_ready=1, o_busy=0, o_starve=0 and o_wb_pkg=all-zeros.
REQ-027 Assertion of i_rst_n mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-028 Entry storage SHALL NOT require reset, since it is masked by count.

Configuration
REQ-029 Macro WB_QUEUE_STARVE_MON_EN SHALL control the starvation monitor.
REQ-030 With WB_QUEUE_STARVE_MON_EN defined:
- an 8-bit counter SHALL increment each cycle count>0 and no pop occurs, saturating at STARVE_LIMIT;
- the counter SHALL clear on pop, flush or empty;
- o_starve SHALL equal (counter==STARVE_LIMIT).
REQ-031 Without WB_QUEUE_STARVE_MON_EN, the counter SHALL be absent and o_starve SHALL be tied 0.

Verification
REQ-032 The bench SHALL cover: DEPTH=2; push A (wren=1) at cycle 0, no ack -> cycle 1 o_wb_pkg=A, o_busy=1, o_ready=1; A held through cycle 5.
REQ-033 The bench SHALL cover: push A, B, then C offered -> o_ready=0 after B, C not stored; ack at cycle 3 -> cycle 4 o_wb_pkg=B, o_ready=1.
REQ-034 The bench SHALL cover: count=1, push C and ack in the same cycle -> count stays 1, head becomes C; 3 wrap cycles keep FIFO order.
REQ-035 The bench SHALL cover: valid=1 with wren=0 offered -> count stays 0 and o_wb_pkg=0; ack on empty -> no state change.
REQ-036 The bench SHALL cover: count=2, i_flush with push and ack -> next cycle count=0, o_busy=0; async i_rst_n low mid-stream -> outputs at reset values before the next edge.
REQ-037 The bench SHALL cover: macro defined, STARVE_LIMIT=4, head unacked -> o_starve=1 at the 4th cycle, cleared the cycle after ack; macro undefined -> o_starve always 0.
